// File: rtl/mine_placer.sv
// mine_placer: random mine map generator driven by a free-running 16-bit Galois LFSR.
// Places exactly NUM_MINES mines, never on the first-clicked tile, and publishes the map atomically.
// Optional feature macro SAFE_NEIGHBOURHOOD_EN: keep the whole 3x3 block around the first click mine-free.
module mine_placer #(
    parameter int          GRID_SIZE = 8,
    parameter int          NUM_MINES = 10,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         TILES     = GRID_SIZE * GRID_SIZE,
    localparam int         IDXW      = $clog2(TILES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gen,
    input  logic [IDXW-1:0]   safe_idx,
    input  logic              load_seed,
    input  logic [15:0]       seed_in,
    output logic [TILES-1:0]  mine_map,
    output logic [IDXW:0]     mine_count,
    output logic              busy,
    output logic              done
);
`ifdef SAFE_NEIGHBOURHOOD_EN
    localparam int EXCL = 9;
`else
    localparam int EXCL = 1;
`endif
    localparam logic [IDXW:0] LAST_CNT = (IDXW + 1)'(NUM_MINES - 1);
    localparam logic [15:0]   TAPS     = 16'hB400;
    if (NUM_MINES < 1 || NUM_MINES > TILES - EXCL || (1 << IDXW) != TILES || TILES > 256 ||
        (IDXW % 2) != 0 || SEED == 16'h0000) begin : g_cfg_err
        $error("mine_placer: invalid GRID_SIZE/NUM_MINES/SEED configuration");
    end
    typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;
    state_t           state_q;
    logic [15:0]      lfsr_q, lfsr_d, lfsr_step, seed_val;
    logic [IDXW-1:0]  safe_q, cand;
    logic [TILES-1:0] work_q, map_q;
    logic [IDXW:0]    count_q;
    logic             busy_q, done_q, idle, excl, accept, last;
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    assign seed_val  = (seed_in == 16'h0000) ? SEED : seed_in;
    assign idle      = (state_q == IDLE) || (state_q == DONE);
    assign lfsr_d    = (idle && load_seed) ? seed_val : lfsr_step;
    assign cand      = lfsr_q[IDXW-1:0];
`ifdef SAFE_NEIGHBOURHOOD_EN
    localparam int RW = IDXW / 2;
    logic [RW-1:0] c_row, c_col, s_row, s_col, d_row, d_col;
    assign c_row = cand[IDXW-1:RW];
    assign c_col = cand[RW-1:0];
    assign s_row = safe_q[IDXW-1:RW];
    assign s_col = safe_q[RW-1:0];
    assign d_row = (c_row > s_row) ? c_row - s_row : s_row - c_row;
    assign d_col = (c_col > s_col) ? c_col - s_col : s_col - c_col;
    assign excl  = (d_row <= RW'(1)) && (d_col <= RW'(1));
`else
    assign excl  = (cand == safe_q);
`endif
    assign accept = (state_q == PLACE) && !work_q[cand] && !excl;
    assign last   = accept && (count_q == LAST_CNT);
    // LFSR advances every cycle; a seed load replaces the advance only while not generating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end
    // Generation FSM: clear working map, place mines by rejection sampling, publish on the final mine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            safe_q  <= '0;
            work_q  <= '0;
            map_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (gen) begin
                        state_q <= CLEAR;
                        safe_q  <= safe_idx;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                CLEAR: begin
                    work_q  <= '0;
                    count_q <= '0;
                    state_q <= PLACE;
                end
                PLACE: begin
                    if (accept) begin
                        work_q[cand] <= 1'b1;
                        count_q      <= count_q + (IDXW + 1)'(1);
                    end
                    if (last) begin
                        map_q   <= work_q | (TILES'(1) << cand);
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mine_map   = map_q;
    assign mine_count = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: scoreboard bench for mine_placer against a behavioural placement model.
module tb_mine_placer;
    typedef struct {
        bit          full;
        logic [63:0] map;
        int          lat;
        int          safe;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gen = 1'b0;
    logic [5:0]  safe_idx = '0;
    logic        load_seed = 1'b0;
    logic [15:0] seed_in = '0;
    logic [63:0] mine_map;
    logic [6:0]  mine_count;
    logic        busy, done;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [63:0] last_map = '0;
    bit          last_known = 1'b1;
    mine_placer dut (
        .clk(clk), .rst(rst), .gen(gen), .safe_idx(safe_idx), .load_seed(load_seed),
        .seed_in(seed_in), .mine_map(mine_map), .mine_count(mine_count), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic bit excluded(int c, int s);
`ifdef SAFE_NEIGHBOURHOOD_EN
        int dr = c / 8 - s / 8;
        int dc = c % 8 - s % 8;
        return dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1;
`else
        return c == s;
`endif
    endfunction
    function automatic void model(input logic [15:0] seed, input int safe, output logic [63:0] map, output int lat);
        logic [15:0] l = (seed == 16'h0000) ? 16'hACE1 : seed;
        int n = 0;
        int k = 0;
        int c;
        map = '0;
        while (n < 10) begin
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
            k++;
            c = int'(l[5:0]);
            if (!map[c] && !excluded(c, safe)) begin
                map[c] = 1'b1;
                n++;
            end
        end
        lat = 1 + k;
    endfunction
    task automatic check_reset_state(input string tag);
        check({tag, "_map"}, mine_map, 64'd0);
        check({tag, "_cnt"}, 64'(mine_count), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask
    task automatic mid_clock_reset(input string tag);
        #2 rst = 1'b0;
        #1 check_reset_state(tag);
        last_map = '0;
        last_known = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask
    task automatic run(input logic [15:0] seed, input bit ld, input int safe, input int glitch, input int abort);
        exp_t e;
        int   cyc = 0;
        @(negedge clk);
        gen = 1'b1;
        load_seed = ld;
        seed_in = seed;
        safe_idx = 6'(safe);
        e.full = ld;
        e.safe = safe;
        e.map = '0;
        e.lat = 0;
        if (ld) model(seed, safe, e.map, e.lat);
        sb.push_back(e);
        @(negedge clk);
        gen = 1'b0;
        load_seed = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
        check("done_fall", 64'(done), 64'd0);
        while (cyc < 70000) begin
            if (abort != 0 && cyc == abort) begin
                mid_clock_reset("abort");
                void'(sb.pop_front());
                return;
            end
            @(negedge clk);
            cyc++;
            if (done) break;
            gen = (cyc == glitch);
            load_seed = (cyc == glitch);
            if (cyc == glitch) begin
                seed_in = 16'hFFFF;
                safe_idx = 6'd63;
            end
            if (last_known) check("map_hold_busy", mine_map, last_map);
        end
        gen = 1'b0;
        load_seed = 1'b0;
        e = sb.pop_front();
        check("done_seen", 64'(done), 64'd1);
        check("busy_end", 64'(busy), 64'd0);
        check("count_end", 64'(mine_count), 64'd10);
        check("popcount", 64'($countones(mine_map)), 64'd10);
        check("safe_clear", 64'(mine_map[e.safe]), 64'd0);
        if (e.full) begin
            check("map", mine_map, e.map);
            check("latency", 64'(cyc), 64'(e.lat));
        end
        last_map = e.full ? e.map : '0;
        last_known = e.full;
        repeat (3) begin
            @(negedge clk);
            check("done_hold", 64'(done), 64'd1);
            if (last_known) check("map_hold_done", mine_map, last_map);
        end
    endtask
    initial begin
        logic [63:0] mask;
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run(16'h0000, 1'b0, 0, 0, 0);
        mid_clock_reset("mid_rst");
        run(16'h0000, 1'b1, 0, 0, 0);
        run(16'hACE1, 1'b1, 0, 0, 0);
        run(16'h1234, 1'b1, 0, 0, 0);
        run(16'h5A5A, 1'b1, 20, 0, 0);
        run(16'h1234, 1'b1, 9, 6, 0);
        run(16'hBEEF, 1'b1, 33, 0, 4);
        run(16'hBEEF, 1'b1, 33, 0, 0);
        run(16'h0001, 1'b1, 63, 0, 0);
`ifdef SAFE_NEIGHBOURHOOD_EN
        run(16'hC0DE, 1'b1, 27, 0, 0);
        mask = '0;
        foreach (mask[i]) mask[i] = (i inside {18, 19, 20, 26, 27, 28, 34, 35, 36});
        check("nbhd27", mine_map & mask, 64'd0);
        run(16'h7777, 1'b1, 7, 0, 0);
        mask = '0;
        foreach (mask[i]) mask[i] = (i inside {6, 7, 14, 15});
        check("nbhd7", mine_map & mask, 64'd0);
`else
        mask = '0;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
